// File: rtl/pixel_pkg.sv
// Shared types and screen geometry for the pixel write path.
package pixel_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [2:0]           colour;
    } fb_write_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when
// the same cycle also pops, so the head slot is recycled.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Clips and linearises the producer pixel stream, buffers the writes and
// drains them into the framebuffer port; overflow is flagged, never stalled.
module pixel_write_buffer
    import pixel_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_x,
    input  logic [6:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              in_plot,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_grant,
    output logic              accepting,
    output logic              drained,
    output logic              overflow,
    output logic [15:0]       clip_count
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WORD_W = ADDR_W + 3;

    pixel_t             pix;
    logic               on_screen;
    logic               take;
    logic               s1_valid;
    logic [ADDR_W-1:0]  s1_addr;
    logic [2:0]         s1_colour;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [WORD_W-1:0]  head;
    state_t             state;
    state_t             state_next;

    assign pix       = '{x: in_x, y: in_y, colour: in_colour};
    assign on_screen = (32'(pix.x) < SCREEN_W) && (32'(pix.y) < SCREEN_H);
    assign take      = accepting && in_plot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_colour <= '0;
        end else begin
            s1_valid <= take && on_screen;
            if (take && on_screen) begin
                s1_addr   <= ADDR_W'(pix.y) * ADDR_W'(SCREEN_W) + ADDR_W'(pix.x);
                s1_colour <= pix.colour;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (take && !on_screen && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid),
        .push_data ({s1_addr, s1_colour}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign fb_we              = !empty;
    assign pop                = fb_we && fb_grant;
    assign {fb_addr, fb_data} = head;

    // A drop outranks a same-cycle clear so the loss is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (s1_valid && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain completes on the edge the last entry leaves, so drained follows the final pop.
    always_comb begin
        state_next = state;
        accepting  = 1'b0;
        drained    = 1'b0;
        case (state)
            RUN: begin
                accepting = 1'b1;
                if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid && (empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                drained    = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench: vector table, directed multi-cycle sequences and random
// traffic, all compared against a queue-based reference model.
module tb_pixel_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        flush;
    logic        clr_ovf;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_grant;
    logic        accepting;
    logic        drained;
    logic        overflow;
    logic [15:0] clip_count;

    always #5 clk = ~clk;

    pixel_write_buffer #(
        .DEPTH  (16),
        .ADDR_W (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_plot    (in_plot),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_grant   (fb_grant),
        .accepting  (accepting),
        .drained    (drained),
        .overflow   (overflow),
        .clip_count (clip_count)
    );

    typedef struct {
        int addr;
        int colour;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int c;
        bit exp_we;
        int exp_addr;
        int exp_clip;
    } vec_t;

    // Reference model: pending pixel, write queue, mode, sticky flag, clip tally.
    wr_t q[$];
    bit  s1_v;
    int  s1_a;
    int  s1_c;
    int  m_state;
    bit  m_ovf;
    int  m_clip;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops;
    int last_pop_cyc;
    int last_addr;
    int drains;
    int drain_cyc;

    vec_t vecs[9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        s1_v    = 1'b0;
        s1_a    = 0;
        s1_c    = 0;
        m_state = 0;
        m_ovf   = 1'b0;
        m_clip  = 0;
    endtask

    task automatic model_step(input int x, input int y, input int c,
                              input bit plot, input bit fl, input bit clr, input bit grant);
        int  old_size;
        bit  old_v;
        bit  pop;
        bit  dropped;
        wr_t w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_size = q.size();
        old_v    = s1_v;
        pop      = (old_size > 0) && grant;
        w.addr   = s1_a;
        w.colour = s1_c;
        if (pop) void'(q.pop_front());
        dropped = 1'b0;
        if (old_v) begin
            if (old_size < 16 || pop) q.push_back(w);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        s1_v = 1'b0;
        if (m_state == 0 && plot) begin
            if (x < 160 && y < 120) begin
                s1_v = 1'b1;
                s1_a = y * 160 + x;
                s1_c = c;
            end else if (m_clip < 65535) begin
                m_clip++;
            end
        end
        case (m_state)
            0: if (fl) m_state = 1;
            1: if (!old_v && q.size() == 0) m_state = 2;
            default: m_state = 0;
        endcase
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic apply_stimulus(input int x, input int y, input int c,
                                  input bit plot, input bit fl, input bit clr, input bit grant);
        in_x      = x[7:0];
        in_y      = y[6:0];
        in_colour = c[2:0];
        in_plot   = plot;
        flush     = fl;
        clr_ovf   = clr;
        fb_grant  = grant;
        @(negedge clk);
        cyc++;
        check_output("fb_we", 32'(fb_we), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_output("fb_addr", 32'(fb_addr), q[0].addr);
            check_output("fb_data", 32'(fb_data), q[0].colour);
        end
        check_output("accepting", 32'(accepting), 32'(m_state == 0));
        check_output("drained", 32'(drained), 32'(m_state == 2));
        check_output("overflow", 32'(overflow), 32'(m_ovf));
        check_output("clip_count", 32'(clip_count), m_clip);
        if (fb_we && fb_grant) begin
            pops++;
            last_pop_cyc = cyc;
            last_addr    = 32'(fb_addr);
        end
        if (drained) begin
            drains++;
            drain_cyc = cyc;
        end
        @(posedge clk);
        model_step(x, y, c, plot, fl, clr, grant);
        #1;
    endtask

    task automatic idle(input int n, input bit grant);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 1'b0, 1'b0, 1'b0, grant);
    endtask

    initial begin
        vecs[0] = '{5,   2,   3, 1'b1, 325,   0};
        vecs[1] = '{0,   0,   1, 1'b1, 0,     0};
        vecs[2] = '{159, 119, 7, 1'b1, 19199, 0};
        vecs[3] = '{160, 0,   2, 1'b0, 0,     1};
        vecs[4] = '{0,   120, 4, 1'b0, 0,     2};
        vecs[5] = '{255, 127, 5, 1'b0, 0,     3};
        vecs[6] = '{159, 0,   6, 1'b1, 159,   3};
        vecs[7] = '{0,   119, 1, 1'b1, 19040, 3};
        vecs[8] = '{100, 60,  2, 1'b1, 9700,  3};

        rst_n     = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
        in_plot   = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        fb_grant  = 1'b0;
        pops      = 0;
        drains    = 0;
        last_pop_cyc = 0;
        drain_cyc = 0;
        last_addr = 0;
        model_reset();

        #12;
        check_output("rst_fb_we", 32'(fb_we), 0);
        check_output("rst_fb_addr", 32'(fb_addr), 0);
        check_output("rst_fb_data", 32'(fb_data), 0);
        check_output("rst_accepting", 32'(accepting), 1);
        check_output("rst_drained", 32'(drained), 0);
        check_output("rst_overflow", 32'(overflow), 0);
        check_output("rst_clip", 32'(clip_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].c, 1'b1, 1'b0, 1'b0, 1'b1);
            apply_stimulus(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_output("vec_we", 32'(fb_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check_output("vec_addr", 32'(fb_addr), vecs[i].exp_addr);
                check_output("vec_data", 32'(fb_data), vecs[i].c);
            end
            check_output("vec_clip", 32'(clip_count), vecs[i].exp_clip);
            idle(1, 1'b1);
        end

        $display("[TB] full screen fill");
        pops = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                apply_stimulus(x, y, (x + y) % 8, 1'b1, 1'b0, 1'b0, 1'b1);
            end
        end
        idle(4, 1'b1);
        check_output("fill_writes", pops, 19200);
        check_output("fill_last_addr", last_addr, 19199);
        check_output("fill_overflow", 32'(overflow), 0);

        $display("[TB] overflow with grant held low");
        for (int i = 0; i < 20; i++) apply_stimulus(i, 10, i % 8, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_output("ovf_set", 32'(overflow), 1);
        check_output("ovf_head", 32'(fb_addr), 1600);
        pops = 0;
        apply_stimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output("ovf_clear", 32'(overflow), 0);
        idle(20, 1'b1);
        check_output("ovf_retained", pops, 16);

        $display("[TB] flush with toggling grant");
        for (int i = 0; i < 10; i++) apply_stimulus(i, 30, i % 8, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        pops   = 0;
        drains = 0;
        apply_stimulus(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("flush_accepting", 32'(accepting), 0);
        for (int i = 0; i < 60 && drains == 0; i++) begin
            apply_stimulus(i, 40, 3, 1'b1, 1'b0, 1'b0, i[0]);
        end
        idle(5, 1'b1);
        check_output("flush_pops", pops, 10);
        check_output("flush_drain_pulses", drains, 1);
        check_output("flush_drain_timing", drain_cyc - last_pop_cyc, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(int'($urandom_range(0, 199)), int'($urandom_range(0, 127)),
                           int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
                           ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                           ($urandom_range(0, 1) == 1));
        end
        idle(40, 1'b1);

        $display("[TB] reset with entries buffered");
        for (int i = 0; i < 8; i++) apply_stimulus(i, 20, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(200, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_output("pre_rst_we", 32'(fb_we), 1);
        rst_n = 1'b0;
        #1;
        check_output("rst_async_we", 32'(fb_we), 0);
        check_output("rst_async_clip", 32'(clip_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pops = 0;
        idle(30, 1'b1);
        check_output("rst_no_stale", pops, 0);
        check_output("rst_clip_zero", 32'(clip_count), 0);
        check_output("rst_ovf_zero", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
Downstream stage of the pixel producers (screen fill, drawing engines). Accepts the one-cycle-per-pixel plot stream (x, y, colour, plot), clips off-screen writes, converts (x,y) to a linear framebuffer address, and buffers writes in a small FIFO. It drains them into the framebuffer RAM write port, which may refuse writes while scan-out owns the memory. Producers have no backpressure, so overflow is detected and flagged, never stalled.

Parameters:
SCREEN_W, 160, pixels per row; valid x is 0..SCREEN_W-1.
SCREEN_H, 120, rows; valid y is 0..SCREEN_H-1.
DEPTH, 16, FIFO entries (power of 2, at least 4).
ADDR_W, 15, framebuffer address width; must cover SCREEN_W*SCREEN_H (19200).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_x  in  8  pixel x
in_y  in  7  pixel y
in_colour  in  3  pixel colour
in_plot  in  1  write strobe, one pixel per cycle when high
flush  in  1  one-cycle request to drain FIFO and report completion
clr_ovf  in  1  clears sticky overflow
fb_addr  out  ADDR_W  framebuffer address = y*SCREEN_W + x
fb_data  out  3  colour
fb_we  out  1  write request; high whenever FIFO non-empty
fb_grant  in  1  memory accepts the write this cycle when fb_we && fb_grant
accepting  out  1  high in RUN (inputs observed), low in DRAIN/DONE
drained  out  1  one-cycle pulse when flush completes
overflow  out  1  sticky; set when a valid pixel is dropped on full FIFO
clip_count  out  16  saturating count of off-screen pixels discarded

Behaviour:
- Reset (async): FIFO emptied, pointers/count 0, state RUN. Outputs: fb_we=0, fb_addr=0, fb_data=0, accepting=1, drained=0, overflow=0, clip_count=0. Reset mid-operation discards all buffered pixels.
- Stage 1 (input register), RUN only: on in_plot=1, register valid = (in_x<SCREEN_W && in_y<SCREEN_H).
  - Clipped pixel: discarded; clip_count increments, saturating at 16'hFFFF.
  - Address is computed in ADDR_W bits with no truncation: y*160 = (y<<7)+(y<<5), plus x.
- Stage 2 (FIFO push): a registered valid pixel is pushed the next cycle.
- Latency: pixel presented at cycle N appears at fb_addr/fb_data with fb_we=1 at N+2 when the FIFO was empty.
- FIFO output is show-ahead: fb_addr/fb_data reflect the head entry combinationally from registered storage. Pop when fb_we && fb_grant.
- Full boundary: push succeeds if count<DEPTH, or if a pop occurs in the same cycle (simultaneous push+pop at full keeps count=DEPTH).
  - Otherwise the pixel is dropped and overflow is set.
  - overflow clears only on clr_ovf or reset; set wins over clr_ovf in the same cycle.
- Empty boundary: fb_we=0. fb_addr/fb_data hold last value (don't-care for checking).
- FSM:
  - RUN: accepting=1. flush=1 -> DRAIN. Stage-1 register contents still push.
  - DRAIN: accepting=0, in_plot ignored. When stage 1 is empty and FIFO count=0 -> DONE.
  - DONE: drained=1 for exactly one cycle -> RUN.
  - flush in DRAIN/DONE is ignored. Unused encodings -> RUN.
- fb_grant low indefinitely: FIFO holds contents; no entry is lost or reordered. Strict FIFO order is preserved.

Decomposition:
- Package pixel_pkg: SCREEN_W/SCREEN_H localparams, pixel_t struct {x[7:0], y[6:0], colour[2:0]}, fb_write_t {addr, colour}, state enum {RUN, DRAIN, DONE}.
- One sub-module: sync_fifo (parameterised width/depth, show-ahead, push/pop/full/empty/count). Top holds the clip/address stage, FSM and counters.

Test Plan:
- Single pixel (x=5,y=2,c=3), fb_grant=1 -> fb_we=1 two cycles later with fb_addr=325, fb_data=3, for one cycle.
- Full 160x120 fill stream, fb_grant=1 -> 19200 writes, addresses 0..19199 in order, overflow=0; corner (159,119) -> addr 19199.
- Clip: pixels (160,0), (0,120), (255,127) -> no fb_we, clip_count=3; valid neighbours still written.
- fb_grant=0 while streaming 20 pixels, DEPTH=16 -> first 16 (plus any same-cycle pop) retained in order, overflow=1. clr_ovf -> overflow=0.
- 10 pixels buffered, fb_grant toggling, flush pulse -> accepting=0, in_plot ignored. drained pulses once, the cycle after the 10th pop.
- Reset asserted with 8 entries buffered -> fb_we=0 immediately. After release, no stale writes emerge and all counters are 0.
